// File: rtl/dec_ib_fifo_ctl.sv
// Decode instruction buffer: circular queue between the aligner and the decode output mux.
// Accepts up to two packets per cycle, retires up to two, and presents the two oldest entries.
module dec_ib_fifo_ctl #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned BRP_W = 23,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             flush,
   input  logic             wr0_valid,
   input  logic             wr1_valid,
   input  logic [31:0]      wr0_instr,
   input  logic [31:0]      wr1_instr,
   input  logic [15:0]      wr0_cinst,
   input  logic [15:0]      wr1_cinst,
   input  logic [36:0]      wr0_pc,
   input  logic [36:0]      wr1_pc,
   input  logic [BRP_W-1:0] wr0_brp,
   input  logic [BRP_W-1:0] wr1_brp,
   input  logic             wr0_dbg_wdata,
   input  logic             wr0_dbg_fence,
   input  logic             rd0_en,
   input  logic             rd1_en,
   output logic             dec_ib0_valid_d_fifo,
   output logic             dec_ib1_valid_d_fifo,
   output logic             dec_ib2_valid_d_fifo,
   output logic             dec_ib3_valid_d_fifo,
   output logic [31:0]      dec_i0_instr_d_fifo,
   output logic [31:0]      dec_i1_instr_d_fifo,
   output logic [15:0]      dec_i0_cinst_d_fifo,
   output logic [15:0]      dec_i1_cinst_d_fifo,
   output logic [36:0]      pc0_fifo,
   output logic [36:0]      pc1_fifo,
   output logic [BRP_W-1:0] dec_i0_brp_fifo,
   output logic [BRP_W-1:0] dec_i1_brp_fifo,
   output logic             dec_debug_wdata_rs1_d_fifo,
   output logic             dec_debug_fence_d_fifo,
   output logic [CNT_W-1:0] fifo_count,
   output logic             ifu_ib_stall,
   output logic             ovf_err,
   output logic             udf_err
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [31:0]      instr_q [DEPTH];
   logic [15:0]      cinst_q [DEPTH];
   logic [36:0]      pc_q    [DEPTH];
   logic [BRP_W-1:0] brp_q   [DEPTH];
   logic             dbgw_q  [DEPTH];
   logic             dbgf_q  [DEPTH];

   logic [PW-1:0]    rd_ptr, wr_ptr, rd_ptr_p1, wr_ptr_p1;
   logic [CNT_W-1:0] count, free_cnt, count_nxt;
   logic [CNT_W-1:0] nwr_req, nwr_acc, nrd_req, nrd_acc;
   logic             wr_ovf, rd_udf, have_one, have_two;

   assign rd_ptr_p1 = rd_ptr + PW'(1);
   assign wr_ptr_p1 = wr_ptr + PW'(1);

   // Acceptance uses the registered count only; slots freed by a same-cycle read are not reusable.
   always_comb begin
      free_cnt  = CNT_W'(DEPTH) - count;
      nwr_req   = wr0_valid ? (wr1_valid ? CNT_W'(2) : CNT_W'(1)) : '0;
      wr_ovf    = (wr1_valid & ~wr0_valid) | (nwr_req > free_cnt);
      nwr_acc   = wr_ovf ? '0 : nwr_req;
      nrd_req   = rd0_en ? (rd1_en ? CNT_W'(2) : CNT_W'(1)) : '0;
      rd_udf    = (rd1_en & ~rd0_en) | (nrd_req > count);
      nrd_acc   = (nrd_req > count) ? count : nrd_req;
      count_nxt = count + nwr_acc - nrd_acc;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + PW'(nrd_acc);
         wr_ptr <= wr_ptr + PW'(nwr_acc);
         count  <= count_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            cinst_q[i] <= '0;
            pc_q[i]    <= '0;
            brp_q[i]   <= '0;
            dbgw_q[i]  <= 1'b0;
            dbgf_q[i]  <= 1'b0;
         end
      end else if (!flush && (nwr_acc != '0)) begin
         instr_q[wr_ptr] <= wr0_instr;
         cinst_q[wr_ptr] <= wr0_cinst;
         pc_q[wr_ptr]    <= wr0_pc;
         brp_q[wr_ptr]   <= wr0_brp;
         dbgw_q[wr_ptr]  <= wr0_dbg_wdata;
         dbgf_q[wr_ptr]  <= wr0_dbg_fence;
         if (nwr_acc == CNT_W'(2)) begin
            instr_q[wr_ptr_p1] <= wr1_instr;
            cinst_q[wr_ptr_p1] <= wr1_cinst;
            pc_q[wr_ptr_p1]    <= wr1_pc;
            brp_q[wr_ptr_p1]   <= wr1_brp;
            dbgw_q[wr_ptr_p1]  <= 1'b0;
            dbgf_q[wr_ptr_p1]  <= 1'b0;
         end
      end
   end

   // Count masking hides stale storage after a flush, which leaves the entries untouched.
   always_comb begin
      have_one = (count != '0);
      have_two = (count > CNT_W'(1));

      dec_ib0_valid_d_fifo = have_one;
      dec_ib1_valid_d_fifo = have_two;
      dec_ib2_valid_d_fifo = (count > CNT_W'(2));
      dec_ib3_valid_d_fifo = (count > CNT_W'(3));

      dec_i0_instr_d_fifo        = have_one ? instr_q[rd_ptr] : '0;
      dec_i0_cinst_d_fifo        = have_one ? cinst_q[rd_ptr] : '0;
      pc0_fifo                   = have_one ? pc_q[rd_ptr]    : '0;
      dec_i0_brp_fifo            = have_one ? brp_q[rd_ptr]   : '0;
      dec_debug_wdata_rs1_d_fifo = have_one & dbgw_q[rd_ptr];
      dec_debug_fence_d_fifo     = have_one & dbgf_q[rd_ptr];

      dec_i1_instr_d_fifo = have_two ? instr_q[rd_ptr_p1] : '0;
      dec_i1_cinst_d_fifo = have_two ? cinst_q[rd_ptr_p1] : '0;
      pc1_fifo            = have_two ? pc_q[rd_ptr_p1]    : '0;
      dec_i1_brp_fifo     = have_two ? brp_q[rd_ptr_p1]   : '0;

      fifo_count   = count;
      ifu_ib_stall = (free_cnt < CNT_W'(2));
      ovf_err      = rst_l & ~flush & wr_ovf;
      udf_err      = rst_l & ~flush & rd_udf;
   end

endmodule

// File: tb/tb_dec_ib_fifo_ctl.sv
// Bench for dec_ib_fifo_ctl: vector table, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_dec_ib_fifo_ctl;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned BRP_W = 23;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             clk, rst_l, flush;
   logic             wr0_valid, wr1_valid;
   logic [31:0]      wr0_instr, wr1_instr;
   logic [15:0]      wr0_cinst, wr1_cinst;
   logic [36:0]      wr0_pc, wr1_pc;
   logic [BRP_W-1:0] wr0_brp, wr1_brp;
   logic             wr0_dbg_wdata, wr0_dbg_fence;
   logic             rd0_en, rd1_en;
   logic             dec_ib0_valid_d_fifo, dec_ib1_valid_d_fifo;
   logic             dec_ib2_valid_d_fifo, dec_ib3_valid_d_fifo;
   logic [31:0]      dec_i0_instr_d_fifo, dec_i1_instr_d_fifo;
   logic [15:0]      dec_i0_cinst_d_fifo, dec_i1_cinst_d_fifo;
   logic [36:0]      pc0_fifo, pc1_fifo;
   logic [BRP_W-1:0] dec_i0_brp_fifo, dec_i1_brp_fifo;
   logic             dec_debug_wdata_rs1_d_fifo, dec_debug_fence_d_fifo;
   logic [CNT_W-1:0] fifo_count;
   logic             ifu_ib_stall, ovf_err, udf_err;

   dec_ib_fifo_ctl #(.DEPTH(DEPTH), .BRP_W(BRP_W)) dut (
      .clk(clk), .rst_l(rst_l), .flush(flush),
      .wr0_valid(wr0_valid), .wr1_valid(wr1_valid),
      .wr0_instr(wr0_instr), .wr1_instr(wr1_instr),
      .wr0_cinst(wr0_cinst), .wr1_cinst(wr1_cinst),
      .wr0_pc(wr0_pc), .wr1_pc(wr1_pc),
      .wr0_brp(wr0_brp), .wr1_brp(wr1_brp),
      .wr0_dbg_wdata(wr0_dbg_wdata), .wr0_dbg_fence(wr0_dbg_fence),
      .rd0_en(rd0_en), .rd1_en(rd1_en),
      .dec_ib0_valid_d_fifo(dec_ib0_valid_d_fifo), .dec_ib1_valid_d_fifo(dec_ib1_valid_d_fifo),
      .dec_ib2_valid_d_fifo(dec_ib2_valid_d_fifo), .dec_ib3_valid_d_fifo(dec_ib3_valid_d_fifo),
      .dec_i0_instr_d_fifo(dec_i0_instr_d_fifo), .dec_i1_instr_d_fifo(dec_i1_instr_d_fifo),
      .dec_i0_cinst_d_fifo(dec_i0_cinst_d_fifo), .dec_i1_cinst_d_fifo(dec_i1_cinst_d_fifo),
      .pc0_fifo(pc0_fifo), .pc1_fifo(pc1_fifo),
      .dec_i0_brp_fifo(dec_i0_brp_fifo), .dec_i1_brp_fifo(dec_i1_brp_fifo),
      .dec_debug_wdata_rs1_d_fifo(dec_debug_wdata_rs1_d_fifo),
      .dec_debug_fence_d_fifo(dec_debug_fence_d_fifo),
      .fifo_count(fifo_count), .ifu_ib_stall(ifu_ib_stall),
      .ovf_err(ovf_err), .udf_err(udf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      instr;
      logic [15:0]      cinst;
      logic [36:0]      pc;
      logic [BRP_W-1:0] brp;
      logic             dw;
      logic             df;
   } ent_t;

   typedef struct {
      logic        f, w0, w1, r0, r1;
      int unsigned cnt;
      logic        ovf, udf;
   } vec_t;

   ent_t q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic ent_t zero_ent();
      ent_t e;
      e.instr = '0; e.cinst = '0; e.pc = '0; e.brp = '0; e.dw = 1'b0; e.df = 1'b0;
      return e;
   endfunction

   function automatic ent_t rand_ent();
      ent_t e;
      e.instr = $urandom;
      e.cinst = 16'($urandom);
      e.pc    = {5'($urandom), $urandom};
      e.brp   = BRP_W'($urandom);
      e.dw    = 1'($urandom);
      e.df    = 1'($urandom);
      return e;
   endfunction

   // Expected visible state derived only from the model queue contents.
   task automatic check_state(input string tag);
      ent_t e0, e1;
      int   sz;
      sz = q.size();
      e0 = zero_ent();
      e1 = zero_ent();
      if (sz > 0) e0 = q[0];
      if (sz > 1) e1 = q[1];
      cmp({tag, ".ib0"}, dec_ib0_valid_d_fifo, sz > 0);
      cmp({tag, ".ib1"}, dec_ib1_valid_d_fifo, sz > 1);
      cmp({tag, ".ib2"}, dec_ib2_valid_d_fifo, sz > 2);
      cmp({tag, ".ib3"}, dec_ib3_valid_d_fifo, sz > 3);
      cmp({tag, ".count"}, fifo_count, sz);
      cmp({tag, ".stall"}, ifu_ib_stall, (DEPTH - sz) < 2);
      cmp({tag, ".i0_instr"}, dec_i0_instr_d_fifo, e0.instr);
      cmp({tag, ".i0_cinst"}, dec_i0_cinst_d_fifo, e0.cinst);
      cmp({tag, ".pc0"}, pc0_fifo, e0.pc);
      cmp({tag, ".i0_brp"}, dec_i0_brp_fifo, e0.brp);
      cmp({tag, ".dbg_wdata"}, dec_debug_wdata_rs1_d_fifo, e0.dw);
      cmp({tag, ".dbg_fence"}, dec_debug_fence_d_fifo, e0.df);
      cmp({tag, ".i1_instr"}, dec_i1_instr_d_fifo, e1.instr);
      cmp({tag, ".i1_cinst"}, dec_i1_cinst_d_fifo, e1.cinst);
      cmp({tag, ".pc1"}, pc1_fifo, e1.pc);
      cmp({tag, ".i1_brp"}, dec_i1_brp_fifo, e1.brp);
   endtask

   // One clock: drive at negedge, check error pulses before the edge, update model, check state.
   task automatic step(input string tag, input logic f, w0, w1, r0, r1,
                       input ent_t e0, input ent_t e1,
                       output logic got_ovf, output logic got_udf);
      int   sz, nwr, nrd;
      logic eo, eu;
      ent_t e1m;
      @(negedge clk);
      flush = f; wr0_valid = w0; wr1_valid = w1; rd0_en = r0; rd1_en = r1;
      wr0_instr = e0.instr; wr0_cinst = e0.cinst; wr0_pc = e0.pc; wr0_brp = e0.brp;
      wr0_dbg_wdata = e0.dw; wr0_dbg_fence = e0.df;
      wr1_instr = e1.instr; wr1_cinst = e1.cinst; wr1_pc = e1.pc; wr1_brp = e1.brp;
      #1;
      sz  = q.size();
      nwr = w0 ? (w1 ? 2 : 1) : 0;
      nrd = r0 ? (r1 ? 2 : 1) : 0;
      eo  = !f && ((w1 && !w0) || (nwr > DEPTH - sz));
      eu  = !f && ((r1 && !r0) || (nrd > sz));
      got_ovf = ovf_err;
      got_udf = udf_err;
      cmp({tag, ".ovf_err"}, got_ovf, eo);
      cmp({tag, ".udf_err"}, got_udf, eu);
      @(posedge clk);
      if (f) begin
         q.delete();
      end else begin
         if (nrd > sz) nrd = sz;
         for (int i = 0; i < nrd; i++) void'(q.pop_front());
         if (!eo && nwr > 0) begin
            q.push_back(e0);
            if (nwr == 2) begin
               e1m = e1; e1m.dw = 1'b0; e1m.df = 1'b0;
               q.push_back(e1m);
            end
         end
      end
      #1;
      check_state(tag);
   endtask

   vec_t tbl[21];
   logic go, gu;
   ent_t a, b;

   initial begin
      tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1};
      tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0};
      tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0};
      tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0};
      tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};

      rst_l = 1'b0; flush = 1'b0;
      wr0_valid = 1'b0; wr1_valid = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0;
      wr0_instr = '0; wr1_instr = '0; wr0_cinst = '0; wr1_cinst = '0;
      wr0_pc = '0; wr1_pc = '0; wr0_brp = '0; wr1_brp = '0;
      wr0_dbg_wdata = 1'b0; wr0_dbg_fence = 1'b0;
      #1;
      check_state("reset");
      cmp("reset.ovf_err", ovf_err, 1'b0);
      cmp("reset.udf_err", udf_err, 1'b0);
      repeat (2) @(negedge clk);
      rst_l = 1'b1;

      // Dual write of two known instructions, then a single retire.
      a = rand_ent(); a.instr = 32'h0000_0013; a.pc = 37'h0_0000_1001;
      b = rand_ent(); b.instr = 32'h0010_0093; b.pc = 37'h0_0000_1009;
      step("dual_wr", 0, 1, 1, 0, 0, a, b, go, gu);
      cmp("dual_wr.ib0_hand", dec_ib0_valid_d_fifo, 1'b1);
      cmp("dual_wr.ib1_hand", dec_ib1_valid_d_fifo, 1'b1);
      cmp("dual_wr.ib2_hand", dec_ib2_valid_d_fifo, 1'b0);
      cmp("dual_wr.i0_hand", dec_i0_instr_d_fifo, 32'h0000_0013);
      cmp("dual_wr.pc1_hand", pc1_fifo, 37'h0_0000_1009);
      step("rd_one", 0, 0, 0, 1, 0, rand_ent(), rand_ent(), go, gu);
      cmp("rd_one.i0_hand", dec_i0_instr_d_fifo, 32'h0010_0093);
      cmp("rd_one.ib1_hand", dec_ib1_valid_d_fifo, 1'b0);
      step("rd_last", 0, 0, 0, 1, 0, rand_ent(), rand_ent(), go, gu);

      for (int i = 0; i < 21; i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         step(t, tbl[i].f, tbl[i].w0, tbl[i].w1, tbl[i].r0, tbl[i].r1,
              rand_ent(), rand_ent(), go, gu);
         cmp({t, ".tbl_ovf"}, go, tbl[i].ovf);
         cmp({t, ".tbl_udf"}, gu, tbl[i].udf);
         cmp({t, ".tbl_count"}, fifo_count, tbl[i].cnt);
      end

      // Fill to seven, then steady dual read/write across the pointer wrap.
      step("pre_fill_flush", 1, 0, 0, 0, 0, rand_ent(), rand_ent(), go, gu);
      for (int i = 0; i < 7; i++) step("fill", 0, 1, 0, 0, 0, rand_ent(), rand_ent(), go, gu);
      cmp("fill.stall7", ifu_ib_stall, 1'b1);
      for (int i = 0; i < 20; i++) step("wrap", 0, 1, 1, 1, 1, rand_ent(), rand_ent(), go, gu);
      cmp("wrap.count5", fifo_count, 5);

      // Asynchronous reset with traffic in flight and an illegal write request.
      @(negedge clk);
      wr0_valid = 1'b0; wr1_valid = 1'b1; rd0_en = 1'b0; rd1_en = 1'b0;
      rst_l = 1'b0;
      #1;
      q.delete();
      check_state("async_rst");
      cmp("async_rst.ovf_err", ovf_err, 1'b0);
      cmp("async_rst.udf_err", udf_err, 1'b0);
      @(negedge clk);
      wr1_valid = 1'b0;
      rst_l = 1'b1;
      @(posedge clk);
      #1;
      check_state("post_rst");

      for (int i = 0; i < 2000; i++) begin
         step("rand", ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
              rand_ent(), rand_ent(), go, gu);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
